// File: rtl/fifo_lifo_ctrl.sv
// fifo_lifo_ctrl: pointer/flag controller for a dual-port RAM with a registered read.
// It runs as a FIFO or as a LIFO over the same storage. Data never passes through this
// block; it only produces the RAM strobes and addresses, occupancy, and status.
module fifo_lifo_ctrl #(
  parameter int adr_width = 6,
  parameter int mem_size  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  output logic                 we_o,
  output logic [adr_width-1:0] adr_wr_o,
  output logic                 rde_o,
  output logic [adr_width-1:0] adr_rd_o,
  output logic                 valid_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [adr_width:0]   count_o,
  output logic                 ovf_o,
  output logic                 udf_o
);

  typedef enum logic {
    MODE_FIFO = 1'b0,
    MODE_LIFO = 1'b1
  } mode_t;

  localparam logic [adr_width:0]   LP_FULL    = (adr_width+1)'(mem_size);
  localparam logic [adr_width:0]   LP_CNT_ONE = (adr_width+1)'(1);
  localparam logic [adr_width-1:0] LP_LAST    = adr_width'(mem_size - 1);
  localparam logic [adr_width-1:0] LP_ONE     = adr_width'(1);

  mode_t                r_mode, w_mode_nxt;
  logic [adr_width-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [adr_width:0]   r_count, w_count_nxt;
  logic                 r_valid, r_ovf, r_udf;
  logic                 w_full, w_empty, w_push_ok, w_pop_ok;
  logic [adr_width-1:0] w_cnt_lo, w_top;

  // Accept decisions, RAM strobes/addresses and next-state computation.
  always_comb begin
    w_full    = (r_count == LP_FULL);
    w_empty   = (r_count == '0);
    w_push_ok = push_i & (~w_full | pop_i);
    w_pop_ok  = pop_i & ~w_empty;
    w_cnt_lo  = r_count[adr_width-1:0];
    w_top     = w_cnt_lo - LP_ONE;

    we_o  = w_push_ok & ~rst;
    rde_o = w_pop_ok & ~rst;

    // A LIFO push with a concurrent pop replaces the top entry. The RAM reads before it
    // writes, so the old top is still returned.
    if (r_mode == MODE_LIFO) begin
      adr_wr_o = w_pop_ok ? w_top : w_cnt_lo;
      adr_rd_o = w_top;
    end else begin
      adr_wr_o = r_wr_ptr;
      adr_rd_o = r_rd_ptr;
    end

    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    w_mode_nxt   = r_mode;

    if (r_mode == MODE_FIFO) begin
      if (w_push_ok) w_wr_ptr_nxt = (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + LP_ONE;
      if (w_pop_ok)  w_rd_ptr_nxt = (r_rd_ptr == LP_LAST) ? '0 : r_rd_ptr + LP_ONE;
    end

    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + LP_CNT_ONE;
      2'b01:   w_count_nxt = r_count - LP_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase

    // The mode can only change while the storage is empty and idle. The FIFO pointers are
    // cleared only on a LIFO->FIFO switch, so an idle empty FIFO keeps its wrap position.
    if (w_empty && !w_push_ok) begin
      w_mode_nxt = mode_t'(mode_i);
      if (r_mode == MODE_LIFO && !mode_i) begin
        w_wr_ptr_nxt = '0;
        w_rd_ptr_nxt = '0;
      end
    end
  end

  // State registers plus the registered valid and overflow/underflow pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode   <= MODE_FIFO;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_mode   <= w_mode_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= w_pop_ok;
      r_ovf    <= push_i & ~w_push_ok;
      r_udf    <= pop_i & ~w_pop_ok;
    end
  end

  assign valid_o = r_valid;
  assign ovf_o   = r_ovf;
  assign udf_o   = r_udf;
  assign count_o = r_count;
  assign full_o  = w_full;
  assign empty_o = w_empty;

endmodule

// File: tb/tb_fifo_lifo_ctrl.sv
// Testbench for fifo_lifo_ctrl. It contains a behavioural 64x32 RAM with a registered
// read and a queue-based reference model. Read data is checked through an
// expected-data scoreboard. The bench applies a constant vector table and then
// hand-written sequences.
module tb_fifo_lifo_ctrl;

  localparam int AW = 6;
  localparam int MS = 64;

  logic          clk;
  logic          rst, mode_i, push_i, pop_i;
  logic [31:0]   din;
  logic          we_o, rde_o, valid_o, full_o, empty_o, ovf_o, udf_o;
  logic [AW-1:0] adr_wr_o, adr_rd_o;
  logic [AW:0]   count_o;

  logic [31:0]   mem [MS];
  logic [31:0]   ram_q;

  logic [31:0]   mq[$];
  logic [31:0]   exp_q[$];
  logic          m_mode;
  int unsigned   m_wr, m_rd;
  logic          chk_on;
  logic          last_we, last_rde;
  logic [AW-1:0] last_adr_wr, last_adr_rd;

  int n_vec;
  int n_err;

  typedef struct {
    logic        r, m, pu, po;
    logic [31:0] d;
    logic [6:0]  cnt;
    logic        emp, ful, ovf, udf, we, rde;
  } vec_t;

  vec_t tbl [11];

  fifo_lifo_ctrl #(.adr_width(AW), .mem_size(MS)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode_i   (mode_i),
    .push_i   (push_i),
    .pop_i    (pop_i),
    .we_o     (we_o),
    .adr_wr_o (adr_wr_o),
    .rde_o    (rde_o),
    .adr_rd_o (adr_rd_o),
    .valid_o  (valid_o),
    .full_o   (full_o),
    .empty_o  (empty_o),
    .count_o  (count_o),
    .ovf_o    (ovf_o),
    .udf_o    (udf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM driven by the DUT's strobes: write on we, registered read-before-write on rde.
  always @(posedge clk) begin
    if (we_o) mem[adr_wr_o] <= din;
    if (rde_o) ram_q <= mem[adr_rd_o];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: whenever valid_o is high, the RAM output must equal the oldest expected word.
  always @(negedge clk) begin
    if (chk_on && valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got valid with no data pending, want none");
      end else begin
        chk("rd_data", ram_q, exp_q.pop_front());
      end
    end
  end

  task automatic model_reset();
    mq.delete();
    m_mode = 1'b0;
    m_wr   = 0;
    m_rd   = 0;
  endtask

  task automatic step(input logic r, input logic m, input logic pu, input logic po,
                      input logic [31:0] d);
    int unsigned   sz;
    logic          f_m, e_m, push_ok, pop_ok, e_we, e_rde, e_ovf, e_udf;
    logic [AW-1:0] e_wr, e_rd;
    rst = r; mode_i = m; push_i = pu; pop_i = po; din = d;
    #1;
    sz      = mq.size();
    f_m     = (sz == MS);
    e_m     = (sz == 0);
    push_ok = pu & (!f_m | po);
    pop_ok  = po & !e_m;
    e_we    = push_ok & !r;
    e_rde   = pop_ok & !r;
    e_ovf   = !r & pu & !push_ok;
    e_udf   = !r & po & !pop_ok;
    if (!m_mode) begin
      e_wr = AW'(m_wr);
      e_rd = AW'(m_rd);
    end else begin
      e_wr = pop_ok ? AW'(sz - 1) : AW'(sz);
      e_rd = AW'(sz - 1);
    end
    chk("we", 32'(we_o), 32'(e_we));
    chk("rde", 32'(rde_o), 32'(e_rde));
    if (e_we) chk("adr_wr", 32'(adr_wr_o), 32'(e_wr));
    if (e_rde) chk("adr_rd", 32'(adr_rd_o), 32'(e_rd));
    last_we = we_o; last_rde = rde_o; last_adr_wr = adr_wr_o; last_adr_rd = adr_rd_o;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (pop_ok) begin
        if (m_mode) begin
          exp_q.push_back(mq[$]);
          void'(mq.pop_back());
        end else begin
          exp_q.push_back(mq.pop_front());
          m_rd = (m_rd == MS - 1) ? 0 : m_rd + 1;
        end
      end
      if (push_ok) begin
        mq.push_back(d);
        if (!m_mode) m_wr = (m_wr == MS - 1) ? 0 : m_wr + 1;
      end
      if (sz == 0 && !push_ok) begin
        if (m_mode && !m) begin
          m_wr = 0;
          m_rd = 0;
        end
        m_mode = m;
      end
    end
    #1;
    chk("count", 32'(count_o), 32'(mq.size()));
    chk("full", 32'(full_o), 32'(mq.size() == MS));
    chk("empty", 32'(empty_o), 32'(mq.size() == 0));
    chk("valid", 32'(valid_o), 32'(e_rde));
    chk("ovf", 32'(ovf_o), 32'(e_ovf));
    chk("udf", 32'(udf_o), 32'(e_udf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0; chk_on = 1'b0;
    rst = 1'b1; mode_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; din = '0;
    model_reset();

    //          r     m     pu    po    d       cnt  emp   ful   ovf   udf   we    rde
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h77, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hA1, 7'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hB2, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hB3, 7'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hB4, 7'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    chk("rst_udf", 32'(udf_o), 32'd0);
    chk("rst_we", 32'(we_o), 32'd0);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].r, tbl[i].m, tbl[i].pu, tbl[i].po, tbl[i].d);
      chk("tbl_we", 32'(last_we), 32'(tbl[i].we));
      chk("tbl_rde", 32'(last_rde), 32'(tbl[i].rde));
      chk("tbl_count", 32'(count_o), 32'(tbl[i].cnt));
      chk("tbl_empty", 32'(empty_o), 32'(tbl[i].emp));
      chk("tbl_full", 32'(full_o), 32'(tbl[i].ful));
      chk("tbl_ovf", 32'(ovf_o), 32'(tbl[i].ovf));
      chk("tbl_udf", 32'(udf_o), 32'(tbl[i].udf));
    end

    // FIFO fill to full, overflow, in-order drain
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 1; i <= 64; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'(i));
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_count", 32'(count_o), 32'd64);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'd65);
    chk("ovf_no_we", 32'(last_we), 32'd0);
    chk("ovf_pulse", 32'(ovf_o), 32'd1);
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
      chk("valid_run", 32'(valid_o), 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("drain_empty", 32'(empty_o), 32'd1);

    // FIFO wrap: the second pass crosses address 63 -> 0
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 40; i++) begin
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'(1000 + rep * 100 + i));
        if (rep == 1 && i == 24) chk("wrap_adr_wr", 32'(last_adr_wr), 32'd0);
      end
      for (int i = 0; i < 40; i++) begin
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        if (rep == 1 && i == 24) chk("wrap_adr_rd", 32'(last_adr_rd), 32'd0);
      end
    end

    // Full FIFO: simultaneous push and pop are both accepted
    for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'(2000 + i));
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'd3000);
    chk("full_pp_count", 32'(count_o), 32'd64);
    for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);

    // Mode lock: mode_i toggled while non-empty is ignored
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'(11 + i));
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

    // LIFO: push 10,20,30; pop -> 30,20,10 at addresses 2,1,0; extra pop underflows
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'(i * 10));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
      chk("lifo_adr_rd", 32'(last_adr_rd), 32'(2 - i));
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
    chk("lifo_udf", 32'(udf_o), 32'd1);
    step(1'b0, 1'b1, 1'b0, 0, 32'd0);

    // LIFO replace-top: push 99 with a pop returns 30, count unchanged
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'(i * 10));
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'd99);
    chk("replace_count", 32'(count_o), 32'd3);
    chk("replace_adr_wr", 32'(last_adr_wr), 32'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 32'd0);

    // Mid-operation reset with push held: no write, contents gone, mode back to FIFO
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'(50 + i));
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd77);
    chk("rst_mid_we", 32'(last_we), 32'd0);
    chk("rst_mid_count", 32'(count_o), 32'd0);
    chk("rst_mid_empty", 32'(empty_o), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h55);
    chk("rst_mid_udf", 32'(udf_o), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h66);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
